// File: rtl/definitions_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : definitions_pkg
//  Purpose  : Shared system constants and the receiver front-end state type.
//  Revision : 1.0  initial release
// ============================================================================
package definitions_pkg;

  localparam int CLOCK_RATE = 1_843_200;
  localparam int BAUD_RATE  = 115_200;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    DATA       = 3'd2,
    STOP       = 3'd3,
    BREAK_WAIT = 3'd4
  } rx_sync_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_bit_sampler_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_bit_sampler_if
//  Purpose  : Line input, enable and per-bit / per-frame outputs of the
//             oversampling receiver front end. break_det exists only when
//             RX_BREAK_DETECT_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
interface uart_rx_bit_sampler_if #(
  parameter int DATA_BITS = 8
);
  localparam int IDX_W = $clog2(DATA_BITS);

  logic             enable;
  logic             rx;
  logic             sample_valid;
  logic             sample_bit;
  logic [IDX_W-1:0] bit_index;
  logic             frame_start;
  logic             frame_done;
  logic             stop_error;
  logic             busy;
`ifdef RX_BREAK_DETECT_EN
  logic             break_det;
`endif

  // Sampler side
  modport master (
    input  enable, rx,
    output sample_valid, sample_bit, bit_index,
    output frame_start, frame_done, stop_error, busy
`ifdef RX_BREAK_DETECT_EN
    , output break_det
`endif
  );

  // Frame assembler / control side
  modport slave (
    output enable, rx,
    input  sample_valid, sample_bit, bit_index,
    input  frame_start, frame_done, stop_error, busy
`ifdef RX_BREAK_DETECT_EN
    , input break_det
`endif
  );

endinterface
`default_nettype wire

// File: rtl/cdc_sync.sv
`default_nettype none
// ============================================================================
//  Module   : cdc_sync
//  Purpose  : Multi-flop metastability chain for a single asynchronous bit.
//  Revision : 1.0  initial release
// ============================================================================
module cdc_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the asynchronous input through the chain; reset to the idle level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {STAGES{RESET_VAL}};
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/uart_rx_bit_sampler.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_bit_sampler
//  Purpose  : Oversampling UART receive front end. Resynchronises on each
//             start edge, majority-votes the samples around mid-bit and emits
//             one strobe per data bit plus frame start/done/error pulses.
//             Optional macro RX_BREAK_DETECT_EN adds break detection.
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx_bit_sampler #(
  parameter int CLOCK_RATE   = definitions_pkg::CLOCK_RATE,
  parameter int BAUD_RATE    = definitions_pkg::BAUD_RATE,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int SYNC_STAGES  = 2,
  parameter int VOTE_SAMPLES = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  uart_rx_bit_sampler_if.master bus
);
  import definitions_pkg::*;

  localparam int OVERSAMPLE = CLOCK_RATE / BAUD_RATE;
  localparam int MID        = OVERSAMPLE / 2;
  localparam int HV         = VOTE_SAMPLES / 2;
  localparam int PH_W       = $clog2(OVERSAMPLE);
  localparam int VC_W       = $clog2(VOTE_SAMPLES + 1);
  localparam int IDX_W      = $clog2(DATA_BITS);

  localparam logic [PH_W-1:0]  WIN_LO    = PH_W'(MID - HV);
  localparam logic [PH_W-1:0]  WIN_HI    = PH_W'(MID + HV);
  localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] BIT_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic [VC_W-1:0]  HALF      = VC_W'(HV);

  // Elaboration-time sanity checks on the configuration
  if (CLOCK_RATE % BAUD_RATE != 0) begin : g_chk_ratio
    $fatal(1, "CLOCK_RATE must be an integer multiple of BAUD_RATE");
  end
  if (OVERSAMPLE < 8) begin : g_chk_os
    $fatal(1, "oversampling ratio must be at least 8");
  end
  if ((VOTE_SAMPLES % 2 == 0) || (VOTE_SAMPLES > MID)) begin : g_chk_vote
    $fatal(1, "VOTE_SAMPLES must be odd and no larger than half a bit");
  end
  if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_chk_data
    $fatal(1, "DATA_BITS must be 5..9");
  end
  if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_chk_stop
    $fatal(1, "STOP_BITS must be 1..2");
  end
  if (SYNC_STAGES < 2) begin : g_chk_sync
    $fatal(1, "SYNC_STAGES must be at least 2");
  end

  logic             rxs;
  logic             rxs_d;
  rx_sync_state_t   state, state_nx;
  logic [PH_W-1:0]  phase, phase_nx;
  logic [VC_W-1:0]  ones;
  logic [VC_W-1:0]  vote_ones;
  logic             in_window;
  logic             vote_now;
  logic             vote;
  logic [IDX_W-1:0] bit_cnt, bit_cnt_nx;
  logic             stop_cnt, stop_cnt_nx;
  logic             stop_flag, stop_flag_nx, flag_v;
  logic             sv_q, sv_nx;
  logic             sbit_q, sbit_nx;
  logic [IDX_W-1:0] bidx_q, bidx_nx;
  logic             fs_q, fs_nx;
  logic             fd_q, fd_nx;
  logic             err_q, err_nx;
`ifdef RX_BREAK_DETECT_EN
  logic             all_zero, all_zero_nx, az_v;
  logic             brk_q, brk_nx;
`endif

  cdc_sync #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_rx_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.rx),
    .q     (rxs)
  );

  // Delayed copy of the synchronised line for falling-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rxs_d <= 1'b1;
    else        rxs_d <= rxs;
  end

  // Majority vote: the window count plus the sample on the last window phase
  assign in_window = (phase >= WIN_LO) && (phase <= WIN_HI);
  assign vote_now  = (phase == WIN_HI) && (state != IDLE) && (state != BREAK_WAIT);
  assign vote_ones = ones + VC_W'(rxs);
  assign vote      = (vote_ones > HALF);

  // Accumulate ones inside the vote window; clear once the vote is taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          ones <= '0;
    else if (in_window && !vote_now && (state != IDLE)) ones <= vote_ones;
    else                                 ones <= '0;
  end

  // Next-state, counter and output-pulse decisions
  always_comb begin
    state_nx     = state;
    phase_nx     = (phase == PH_LAST) ? '0 : phase + PH_W'(1);
    bit_cnt_nx   = bit_cnt;
    stop_cnt_nx  = stop_cnt;
    stop_flag_nx = stop_flag;
    flag_v       = stop_flag;
    sv_nx        = 1'b0;
    sbit_nx      = sbit_q;
    bidx_nx      = bidx_q;
    fs_nx        = 1'b0;
    fd_nx        = 1'b0;
    err_nx       = 1'b0;
`ifdef RX_BREAK_DETECT_EN
    all_zero_nx  = all_zero;
    az_v         = all_zero;
    brk_nx       = 1'b0;
`endif
    case (state)
      IDLE: begin
        phase_nx = '0;
        if (rxs_d && !rxs) state_nx = START;
      end
      START: begin
        if (vote_now) begin
          if (vote) begin
            state_nx = IDLE;
            phase_nx = '0;
          end else begin
            fs_nx        = 1'b1;
            stop_flag_nx = 1'b0;
`ifdef RX_BREAK_DETECT_EN
            all_zero_nx  = 1'b1;
`endif
          end
        end else if (phase == PH_LAST) begin
          state_nx   = DATA;
          bit_cnt_nx = '0;
        end
      end
      DATA: begin
        if (vote_now) begin
          sv_nx   = 1'b1;
          sbit_nx = vote;
          bidx_nx = bit_cnt;
`ifdef RX_BREAK_DETECT_EN
          if (vote) all_zero_nx = 1'b0;
`endif
        end
        if (phase == PH_LAST) begin
          if (bit_cnt == BIT_LAST) begin
            state_nx    = STOP;
            stop_cnt_nx = 1'b0;
          end else begin
            bit_cnt_nx = bit_cnt + IDX_W'(1);
          end
        end
      end
      STOP: begin
        if (vote_now) begin
          flag_v = stop_flag | ~vote;
`ifdef RX_BREAK_DETECT_EN
          az_v   = all_zero & ~vote;
`endif
          if (stop_cnt == STOP_LAST) begin
            // Leave at the last vote so a back-to-back start edge is caught
            fd_nx    = 1'b1;
            err_nx   = flag_v;
            state_nx = IDLE;
            phase_nx = '0;
`ifdef RX_BREAK_DETECT_EN
            if (az_v) begin
              brk_nx   = 1'b1;
              err_nx   = 1'b0;
              state_nx = BREAK_WAIT;
            end
`endif
          end else begin
            stop_cnt_nx  = stop_cnt + 1'b1;
            stop_flag_nx = flag_v;
`ifdef RX_BREAK_DETECT_EN
            all_zero_nx  = az_v;
`endif
          end
        end
      end
`ifdef RX_BREAK_DETECT_EN
      BREAK_WAIT: begin
        phase_nx = '0;
        if (rxs) state_nx = IDLE;
      end
`endif
      default: begin
        state_nx = IDLE;
        phase_nx = '0;
      end
    endcase
    // Disable wins over everything and drops any pulse decided this cycle
    if (!bus.enable) begin
      state_nx = IDLE;
      phase_nx = '0;
      sv_nx    = 1'b0;
      sbit_nx  = sbit_q;
      bidx_nx  = bidx_q;
      fs_nx    = 1'b0;
      fd_nx    = 1'b0;
      err_nx   = 1'b0;
`ifdef RX_BREAK_DETECT_EN
      brk_nx   = 1'b0;
`endif
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      phase     <= '0;
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
      stop_flag <= 1'b0;
      sv_q      <= 1'b0;
      sbit_q    <= 1'b0;
      bidx_q    <= '0;
      fs_q      <= 1'b0;
      fd_q      <= 1'b0;
      err_q     <= 1'b0;
`ifdef RX_BREAK_DETECT_EN
      all_zero  <= 1'b0;
      brk_q     <= 1'b0;
`endif
    end else begin
      state     <= state_nx;
      phase     <= phase_nx;
      bit_cnt   <= bit_cnt_nx;
      stop_cnt  <= stop_cnt_nx;
      stop_flag <= stop_flag_nx;
      sv_q      <= sv_nx;
      sbit_q    <= sbit_nx;
      bidx_q    <= bidx_nx;
      fs_q      <= fs_nx;
      fd_q      <= fd_nx;
      err_q     <= err_nx;
`ifdef RX_BREAK_DETECT_EN
      all_zero  <= all_zero_nx;
      brk_q     <= brk_nx;
`endif
    end
  end

  assign bus.sample_valid = sv_q;
  assign bus.sample_bit   = sbit_q;
  assign bus.bit_index    = bidx_q;
  assign bus.frame_start  = fs_q;
  assign bus.frame_done   = fd_q;
  assign bus.stop_error   = err_q;
  assign bus.busy         = (state != IDLE);
`ifdef RX_BREAK_DETECT_EN
  assign bus.break_det    = brk_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_bit_sampler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_bit_sampler
//  Purpose  : Directed frames against a frame-schedule model of the receiver,
//             compared every cycle, plus literal per-frame expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx_bit_sampler;

  localparam int OS   = 16;
  localparam int MID  = OS / 2;
  localparam int HV   = 1;
  localparam int SYNC = 2;
  localparam int DB   = 8;
  localparam int SB   = 1;
  localparam int HIST = 8192;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_rx_bit_sampler_if #(.DATA_BITS(DB)) bus ();

  uart_rx_bit_sampler #(
    .CLOCK_RATE   (1_843_200),
    .BAUD_RATE    (115_200),
    .DATA_BITS    (DB),
    .STOP_BITS    (SB),
    .SYNC_STAGES  (SYNC),
    .VOTE_SAMPLES (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- model: frame schedule derived from pin history --------
  logic rx_hist [0:HIST-1];
  int   edge_n = -1;
  logic m_in_frame = 0, m_bw = 0;
  int   m_o = 0;
  logic m_flag = 0, m_az = 0;
  logic m_sv = 0, m_bit = 0, m_fs = 0, m_fd = 0, m_se = 0, m_bd = 0;
  logic [2:0] m_idx = '0;

  function automatic logic rx_at(input int e);
    if (e < 0 || e >= HIST) return 1'b1;
    return rx_hist[e];
  endfunction

  // Majority over the three pin samples nearest the middle of bit j
  function automatic logic vote_of(input int o, input int j);
    int first = o + OS * j + (MID - HV) - SYNC + 1;
    int cnt = 0;
    for (int i = 0; i < 2 * HV + 1; i++) cnt += int'(rx_at(first + i));
    return cnt > HV;
  endfunction

  task automatic model_step(input int e, input logic rst, input logic en);
    m_sv = 0; m_fs = 0; m_fd = 0; m_se = 0; m_bd = 0;
    if (!rst) begin
      m_in_frame = 0; m_bw = 0; m_bit = 0; m_idx = '0;
    end else if (!en) begin
      m_in_frame = 0; m_bw = 0;
    end else if (m_in_frame) begin
      int d = e - m_o - (MID + HV + 1);
      if (d >= 0 && d % OS == 0) begin
        int   j = d / OS;
        logic v = vote_of(m_o, j);
        if (j == 0) begin
          if (v) m_in_frame = 0;
          else begin m_fs = 1; m_flag = 0; m_az = 1; end
        end else if (j <= DB) begin
          m_sv = 1; m_bit = v; m_idx = 3'(j - 1);
          if (v) m_az = 0;
        end else begin
          if (!v) m_flag = 1;
          if (v) m_az = 0;
          if (j == DB + SB) begin
            m_fd = 1; m_in_frame = 0; m_se = m_flag;
`ifdef RX_BREAK_DETECT_EN
            if (m_az) begin m_bd = 1; m_se = 0; m_bw = 1; end
`endif
          end
        end
      end
    end else if (m_bw) begin
      if (rx_at(e - SYNC)) m_bw = 0;
    end else if (!rx_at(e - SYNC) && rx_at(e - SYNC - 1)) begin
      m_in_frame = 1; m_o = e;
    end
  endtask

  function automatic logic [9:0] dut_vec();
    logic brk;
`ifdef RX_BREAK_DETECT_EN
    brk = bus.break_det;
`else
    brk = 1'b0;
`endif
    return {bus.busy, bus.sample_valid, bus.sample_bit, bus.bit_index,
            bus.frame_start, bus.frame_done, bus.stop_error, brk};
  endfunction

  function automatic logic [9:0] exp_vec();
    return {m_in_frame | m_bw, m_sv, m_bit, m_idx, m_fs, m_fd, m_se, m_bd};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- per-cycle compare and capture -----------------------
  logic cap_bit [$];
  int   cap_idx [$];
  int   cnt_fs = 0, cnt_fd = 0, cnt_bd = 0, last_se = 0, last_sv = -1;

  always @(posedge clk) begin
    edge_n++;
    if (edge_n < HIST) rx_hist[edge_n] = bus.rx;
    model_step(edge_n, rst_n, bus.enable);
    #1;
    n_cmp++;
    if (dut_vec() !== exp_vec()) begin
      n_bad++;
      $display("FAIL outputs @edge %0d: got %b, expected %b (busy,sv,bit,idx[3],fs,fd,err,brk)",
               edge_n, dut_vec(), exp_vec());
    end
    if (bus.frame_start) begin cnt_fs++; last_sv = -1; end
    if (bus.sample_valid) begin
      cap_bit.push_back(bus.sample_bit);
      cap_idx.push_back(int'(bus.bit_index));
      if (last_sv >= 0) chk("sv_spacing", edge_n - last_sv, OS);
      last_sv = edge_n;
    end
    if (bus.frame_done) begin cnt_fd++; last_se = int'(bus.stop_error); end
`ifdef RX_BREAK_DETECT_EN
    if (bus.break_det) cnt_bd++;
`endif
  end

  // ---------------- stimulus ---------------------------------------------
  task automatic clr();
    cap_bit.delete(); cap_idx.delete();
    cnt_fs = 0; cnt_fd = 0; cnt_bd = 0; last_se = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(negedge clk); bus.rx = 1'b1; end
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stopv,
                            input int glitch_b, input int dis_b, input int rst_b);
    logic [9:0] bits;
    bits = {stopv, data, 1'b0};
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < OS; c++) begin
        @(negedge clk);
        bus.rx = bits[b];
        if (b == glitch_b && c == 9) bus.rx = 1'b0;
        if (b == dis_b && c == 3) bus.enable = 1'b0;
        if (b == rst_b && c == 4) begin
          bus.rx = 1'b1;
          rst_n  = 1'b0;
          #1;
          chk("async_reset_outputs", int'(dut_vec()), 0);
          repeat (4) @(negedge clk);
          rst_n = 1'b1;
          return;
        end
      end
    end
  endtask

  task automatic check_frame(input string name, input logic [7:0] bits,
                             input int exp_fd, input int exp_se);
    chk({name, "_frame_start"}, cnt_fs, 1);
    chk({name, "_strobes"}, cap_bit.size(), DB);
    for (int i = 0; i < cap_bit.size() && i < DB; i++) begin
      chk($sformatf("%s_bit%0d", name, i), int'(cap_bit[i]), int'(bits[i]));
      chk($sformatf("%s_idx%0d", name, i), cap_idx[i], i);
    end
    chk({name, "_frame_done"}, cnt_fd, exp_fd);
    chk({name, "_stop_error"}, last_se, exp_se);
  endtask

  initial begin
    bus.rx = 1'b1;
    bus.enable = 1'b1;
    repeat (4) @(negedge clk);
    chk("reset_state", int'(dut_vec()), 0);
    rst_n = 1'b1;
    idle(5);

    // 1: 0x55 with good stop bit
    clr(); send_frame(8'h55, 1'b1, -1, -1, -1); idle(20);
    check_frame("f55", 8'b0101_0101, 1, 0);

    // 2: 4-cycle low pulse is a false start
    clr();
    repeat (4) begin @(negedge clk); bus.rx = 1'b0; end
    idle(30);
    chk("false_start_fs", cnt_fs, 0);
    chk("false_start_sv", cap_bit.size(), 0);
    chk("false_start_busy", int'(bus.busy), 0);

    // 3: 0xA5 with stop bit 0 (bits 1,0,1,0,0,1,0,1)
    clr(); send_frame(8'hA5, 1'b0, -1, -1, -1); idle(20);
    check_frame("fA5", 8'b1010_0101, 1, 1);

    // 4: 0xFF with one low cycle at mid-bit of data bit 3
    clr(); send_frame(8'hFF, 1'b1, 4, -1, -1); idle(20);
    check_frame("fFF_glitch", 8'hFF, 1, 0);

    // 5a: disable during data bit 4 of 0x3C, then 0x81 received normally
    clr(); send_frame(8'h3C, 1'b1, -1, 5, -1); idle(8);
    chk("dis_busy", int'(bus.busy), 0);
    bus.enable = 1'b1; idle(10);
    chk("dis_strobes", cap_bit.size(), 4);
    chk("dis_frame_done", cnt_fd, 0);
    clr(); send_frame(8'h81, 1'b1, -1, -1, -1); idle(20);
    check_frame("f81", 8'b1000_0001, 1, 0);

    // 5b: enable rises while rx is held low: no start without a new edge
    clr();
    @(negedge clk); bus.enable = 1'b0; bus.rx = 1'b0;
    repeat (10) @(negedge clk);
    bus.enable = 1'b1;
    repeat (20) @(negedge clk);
    chk("en_low_line_fs", cnt_fs, 0);
    chk("en_low_line_busy", int'(bus.busy), 0);
    idle(10);

    // 5c: asynchronous reset in the middle of a frame, then recovery
    clr(); send_frame(8'h55, 1'b1, -1, -1, 3); idle(20);
    clr(); send_frame(8'h5A, 1'b1, -1, -1, -1); idle(20);
    check_frame("f5A_after_rst", 8'b0101_1010, 1, 0);

    // 6: line held low for 20 bit times
    clr();
    repeat (20 * OS) begin @(negedge clk); bus.rx = 1'b0; end
    chk("break_frame_start", cnt_fs, 1);
    chk("break_frame_done", cnt_fd, 1);
`ifdef RX_BREAK_DETECT_EN
    chk("break_det_pulses", cnt_bd, 1);
    chk("break_stop_error", last_se, 0);
`else
    chk("break_stop_error", last_se, 1);
`endif
    idle(20);
    chk("break_no_restart", cnt_fs, 1);
    clr(); send_frame(8'h0F, 1'b1, -1, -1, -1); idle(20);
    check_frame("f0F_after_break", 8'b0000_1111, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
